// File: rtl/branch_resolve_unit_if.sv
// Branch resolve unit bus interface.
// Bundles the IF-side prediction lookup and the ID-side resolve request and
// response. clk/rst are not part of the bundle.
//   master : pipeline side; drives if_pc and the ID request, reads results
//   slave  : branch_resolve_unit side
//   if_pc, pred_taken                       IF lookup / prediction
//   id_valid, id_pc, id_pred_taken,
//   branch_CMD, Rs_Value, Rt_value          ID resolve request
//   branch_Cond, mispredict                 ID resolve result (combinational)
interface branch_resolve_unit_if #(
  parameter int WORD_LEN = 32
);
  logic [WORD_LEN-1:0] if_pc;
  logic                pred_taken;
  logic                id_valid;
  logic [WORD_LEN-1:0] id_pc;
  logic                id_pred_taken;
  logic [2:0]          branch_CMD;
  logic [WORD_LEN-1:0] Rs_Value;
  logic [WORD_LEN-1:0] Rt_value;
  logic                branch_Cond;
  logic                mispredict;

  modport master (
    output if_pc, id_valid, id_pc, id_pred_taken, branch_CMD, Rs_Value, Rt_value,
    input  pred_taken, branch_Cond, mispredict
  );

  modport slave (
    input  if_pc, id_valid, id_pc, id_pred_taken, branch_CMD, Rs_Value, Rt_value,
    output pred_taken, branch_Cond, mispredict
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Resolves the branch condition of the instruction in ID and owns a
// PC-indexed table of 2-bit saturating counters that predicts direction at IF.
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   bru (slave)   IF lookup + ID resolve bundle (see branch_resolve_unit_if)
//   br_count      resolved branch/jump count (stats build only, else 0)
//   mispred_count mispredict count (stats build only, else 0)
// Optional feature: define BR_STATS_EN to build saturating statistic
// counters; when undefined the stats ports are tied to 0 with no flops.
module branch_resolve_unit #(
  parameter int WORD_LEN  = 32,
  parameter int PHT_DEPTH = 64,
  parameter int STAT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_unit_if.slave  bru,
  output logic [STAT_W-1:0]     br_count,
  output logic [STAT_W-1:0]     mispred_count
);
  localparam int IDX_W = $clog2(PHT_DEPTH);

  localparam logic [2:0] CMD_NONE = 3'd0;
  localparam logic [2:0] CMD_JUMP = 3'd1;
  localparam logic [2:0] CMD_BEQ  = 3'd2;
  localparam logic [2:0] CMD_BNE  = 3'd3;
  localparam logic [2:0] CMD_BEZ  = 3'd4;
  localparam logic [2:0] CMD_BLTZ = 3'd5;
  localparam logic [2:0] CMD_BGEZ = 3'd6;
  localparam logic [2:0] CMD_BGTZ = 3'd7;

  logic [1:0]       pht [PHT_DEPTH];
  logic [IDX_W-1:0] if_idx, id_idx;
  logic             cond_raw;
  logic             rs_zero, rs_neg;
  logic             pht_upd;

  // Word offset and upper PC bits are ignored; aliasing PCs share an entry.
  assign if_idx = bru.if_pc[IDX_W+1:2];
  assign id_idx = bru.id_pc[IDX_W+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bru.if_pc[WORD_LEN-1:IDX_W+2], bru.if_pc[1:0],
                            bru.id_pc[WORD_LEN-1:IDX_W+2], bru.id_pc[1:0]};

  // Lookup reads the registered table: a same-cycle update is not bypassed.
  assign bru.pred_taken = pht[if_idx][1];

  assign rs_zero = (bru.Rs_Value == '0);
  assign rs_neg  = bru.Rs_Value[WORD_LEN-1];

  always_comb begin
    cond_raw = 1'b0;
    case (bru.branch_CMD)
      CMD_NONE: cond_raw = 1'b0;
      CMD_JUMP: cond_raw = 1'b1;
      CMD_BEQ:  cond_raw = (bru.Rs_Value == bru.Rt_value);
      CMD_BNE:  cond_raw = (bru.Rs_Value != bru.Rt_value);
      CMD_BEZ:  cond_raw = rs_zero;
      CMD_BLTZ: cond_raw = rs_neg;
      CMD_BGEZ: cond_raw = ~rs_neg;
      CMD_BGTZ: cond_raw = ~rs_neg & ~rs_zero;
      default:  cond_raw = 1'b0;
    endcase
  end

  assign bru.branch_Cond = bru.id_valid & cond_raw;
  assign bru.mispredict  = bru.id_valid & (bru.branch_CMD != CMD_NONE) &
                           (bru.branch_Cond != bru.id_pred_taken);

  // Only conditional branches train; jumps are always taken and would just
  // pollute the entry.
  assign pht_upd = bru.id_valid & (bru.branch_CMD >= CMD_BEQ);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PHT_DEPTH; i++) pht[i] <= 2'b01;
    end else if (pht_upd) begin
      if (bru.branch_Cond) begin
        if (pht[id_idx] != 2'b11) pht[id_idx] <= pht[id_idx] + 2'b01;
      end else begin
        if (pht[id_idx] != 2'b00) pht[id_idx] <= pht[id_idx] - 2'b01;
      end
    end
  end

`ifdef BR_STATS_EN
  logic br_evt;
  assign br_evt = bru.id_valid & (bru.branch_CMD != CMD_NONE);

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (br_evt && (br_count != '1))
        br_count <= br_count + STAT_W'(1);
      if (bru.mispredict && (mispred_count != '1))
        mispred_count <= mispred_count + STAT_W'(1);
    end
  end
`else
  assign br_count      = '0;
  assign mispred_count = '0;
`endif

endmodule
